// File: rtl/booth_sched_pkg.sv
// Shared types and defaults for the Booth multiplier scheduler.
package booth_sched_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int NB_DEF      = 32;
    localparam int NREQ_DEF    = 4;
    localparam int WDOG_MARGIN = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: highest priority at ptr, then ptr+1, ... wrapping.
module rr_arbiter #(
    parameter  int NREQ = 4,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_valid
);

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   first;
    logic [2*NREQ-1:0] grant_dbl;
    logic [IDW-1:0]    idx_chain [NREQ+1];

    // Rotate requests so bit 0 is the requester at ptr, pick the lowest set bit,
    // then rotate the one-hot result back.
    assign req_dbl = {req, req};
    assign rot     = enable ? NREQ'(req_dbl >> ptr) : '0;

    assign first[0] = rot[0];
    for (genvar gi = 1; gi < NREQ; gi++) begin : g_first
        assign first[gi] = rot[gi] & ~(|rot[gi-1:0]);
    end

    assign grant_dbl   = {first, first} << ptr;
    assign grant       = grant_dbl[2*NREQ-1:NREQ];
    assign grant_valid = |first;

    assign idx_chain[0] = '0;
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_enc
        assign idx_chain[gi+1] = idx_chain[gi] | (grant[gi] ? IDW'(gi) : '0);
    end
    assign grant_idx = idx_chain[NREQ];

endmodule

// File: rtl/booth_mul_sched.sv
// Shares one sequential Booth multiplier among NREQ requesters, round-robin.
// Optional watchdog abort enabled by defining BOOTH_SCHED_WDOG_EN.
module booth_mul_sched
    import booth_sched_pkg::*;
#(
    parameter  int NB   = NB_DEF,
    parameter  int NREQ = NREQ_DEF,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ*NB-1:0] req_a,
    input  logic [NREQ*NB-1:0] req_b,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [2*NB-1:0]    resp_product,
    output logic [IDW-1:0]     resp_id,
    output logic               resp_err,
    output logic               mul_start,
    output logic [NB-1:0]      mul_a,
    output logic [NB-1:0]      mul_b,
    input  logic [2*NB-1:0]    mul_product,
    input  logic               mul_ready
);

    state_t            state_reg, state_next;
    logic [NB-1:0]     a_q, b_q;
    logic [IDW-1:0]    id_q;
    logic [IDW-1:0]    ptr_reg;
    logic [2*NB-1:0]   product_reg;
    logic [NREQ-1:0]   grant;
    logic [IDW-1:0]    grant_idx;
    logic              grant_valid;
    logic              wdog_fire;
    logic [NB-1:0]     a_arr [NREQ];
    logic [NB-1:0]     b_arr [NREQ];

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign a_arr[gi] = req_a[gi*NB +: NB];
        assign b_arr[gi] = req_b[gi*NB +: NB];
    end

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req         (req_valid),
        .ptr         (ptr_reg),
        .enable      (state_reg == IDLE),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (grant_valid) state_next = LAUNCH;
            LAUNCH:  state_next = BUSY;
            BUSY:    if (mul_ready || wdog_fire) state_next = RESP;
            RESP:    if (resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            id_q        <= '0;
            ptr_reg     <= '0;
            product_reg <= '0;
        end else begin
            if (state_reg == IDLE && grant_valid) begin
                a_q     <= a_arr[grant_idx];
                b_q     <= b_arr[grant_idx];
                id_q    <= grant_idx;
                ptr_reg <= (grant_idx == IDW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
            end
            // mul_ready beats a same-cycle watchdog expiry
            if (state_reg == BUSY) begin
                if (mul_ready) begin
                    product_reg <= mul_product;
                end else if (wdog_fire) begin
                    product_reg <= '0;
                end
            end
        end
    end

`ifdef BOOTH_SCHED_WDOG_EN
    localparam int WDOG_LIMIT = NB/2 + WDOG_MARGIN;
    localparam int WDW        = $clog2(WDOG_LIMIT + 1);

    logic [WDW-1:0] wdog_cnt_reg;
    logic           err_reg;

    always_ff @(posedge clk) begin
        if (rst || state_reg != BUSY) begin
            wdog_cnt_reg <= '0;
        end else begin
            wdog_cnt_reg <= wdog_cnt_reg + 1'b1;
        end
    end

    // Fires on the BUSY cycle whose count reaches the limit.
    assign wdog_fire = (state_reg == BUSY) && (wdog_cnt_reg == WDW'(WDOG_LIMIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg <= 1'b0;
        end else if (state_reg == BUSY) begin
            if (mul_ready) begin
                err_reg <= 1'b0;
            end else if (wdog_fire) begin
                err_reg <= 1'b1;
            end
        end
    end

    assign resp_err = err_reg;
`else
    assign wdog_fire = 1'b0;
    assign resp_err  = 1'b0;
`endif

    assign req_ready    = grant;
    assign resp_valid   = (state_reg == RESP);
    assign resp_product = product_reg;
    assign resp_id      = id_q;
    assign mul_start    = (state_reg == LAUNCH);
    assign mul_a        = a_q;
    assign mul_b        = b_q;

endmodule

// File: tb/tb_booth_mul_sched.sv
// Directed bench for booth_mul_sched with a behavioural NB/2-cycle multiplier.
// Define BOOTH_SCHED_WDOG_EN to also exercise the watchdog abort.
module tb_booth_mul_sched;

    localparam int NB   = 32;
    localparam int NREQ = 4;
    localparam int LAT  = NB/2 + 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NREQ-1:0]  req_valid = '0;
    logic [NREQ-1:0]  req_ready;
    logic [NREQ*NB-1:0] req_a = '0;
    logic [NREQ*NB-1:0] req_b = '0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [2*NB-1:0]  resp_product;
    logic [1:0]       resp_id;
    logic             resp_err;
    logic             mul_start;
    logic [NB-1:0]    mul_a, mul_b;
    logic [2*NB-1:0]  mul_product = '0;
    logic             mul_ready = 1'b0;

    int total = 0;
    int bad   = 0;
    int mcnt  = 0;
    logic stall = 1'b0;

    always #5 clk = ~clk;

    booth_mul_sched #(.NB(NB), .NREQ(NREQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_product (resp_product),
        .resp_id      (resp_id),
        .resp_err     (resp_err),
        .mul_start    (mul_start),
        .mul_a        (mul_a),
        .mul_b        (mul_b),
        .mul_product  (mul_product),
        .mul_ready    (mul_ready)
    );

    // Multiplier stand-in: start restarts it, ready rises NB/2 edges later.
    always @(posedge clk) begin
        if (mul_start) begin
            mcnt        <= NB/2;
            mul_ready   <= 1'b0;
            mul_product <= $signed(mul_a) * $signed(mul_b);
        end else if (mcnt > 0) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1 && !stall) mul_ready <= 1'b1;
        end
    end

    typedef struct {
        int          id;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] prod;
    } vec_t;

    vec_t vecs [6];
    vec_t rr   [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
        req_a[id*NB +: NB] = a;
        req_b[id*NB +: NB] = b;
        req_valid[id]      = 1'b1;
    endtask

    // Called at a negedge; returns with time just after that or a later negedge.
    task automatic await_grant(input int exp_id, output int gid);
        gid = -1;
        for (int c = 0; c < 50; c++) begin
            #1;
            if (req_ready != '0) begin
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid = i;
                break;
            end
            @(negedge clk);
        end
        chk("grant_seen", 64'(gid >= 0), 64'd1);
        chk("grant_id", 64'(gid), 64'(exp_id));
        chk("grant_onehot", 64'($onehot(req_ready)), 64'd1);
        if (gid < 0) gid = exp_id;
    endtask

    task automatic finish_job(input int gid, input logic [63:0] exp_prod, input int exp_lat,
                              input logic exp_err, input int hold, input int extra);
        int lat;
        @(negedge clk);
        req_valid[gid] = 1'b0;
        if (extra >= 0) req_valid[extra] = 1'b1;
        #1;
        chk("launch_start", 64'(mul_start), 64'd1);
        chk("launch_ready", 64'(req_ready), 64'd0);
        lat = 0;
        while (!resp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("product", resp_product, exp_prod);
        chk("resp_id", 64'(resp_id), 64'(gid));
        chk("resp_err", 64'(resp_err), 64'(exp_err));
        $display("job id=%0d a=%h b=%h product=%h err=%0d lat=%0d",
                 gid, mul_a, mul_b, resp_product, resp_err, lat);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            #1;
            chk("hold_valid", 64'(resp_valid), 64'd1);
            chk("hold_product", resp_product, exp_prod);
            chk("hold_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        #1;
        chk("resp_phase_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        resp_ready = 1'b0;
        #1;
        chk("post_valid", 64'(resp_valid), 64'd0);
    endtask

    task automatic run_single(input vec_t v);
        int g;
        @(negedge clk);
        set_req(v.id, v.a, v.b);
        await_grant(v.id, g);
        finish_job(g, v.prod, LAT, 1'b0, 0, -1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        int g;
        vecs[0] = '{0, 32'd3,        -32'sd5,      -64'sd15};
        vecs[1] = '{2, 32'd12345,    -32'sd678,    -64'sd8369910};
        vecs[2] = '{3, 32'h80000000, 32'h80000000, 64'h4000000000000000};
        vecs[3] = '{1, 32'h80000000, 32'h7FFFFFFF, 64'hC000000080000000};
        vecs[4] = '{3, -32'sd1,      32'd5,        -64'sd5};
        vecs[5] = '{0, 32'd0,        32'h12345678, 64'd0};
        rr[0]   = '{0, 32'd2,        32'd7,        64'd14};
        rr[1]   = '{1, -32'sd4,      32'd9,        -64'sd36};
        rr[2]   = '{2, 32'h7FFFFFFF, 32'd2,        64'h00000000FFFFFFFE};
        rr[3]   = '{3, -32'sd1,      -32'sd1,      64'd1};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_mul_start", 64'(mul_start), 64'd0);
        chk("rst_product", resp_product, 64'd0);
        chk("rst_resp_id", 64'(resp_id), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);

        for (int i = 0; i < 6; i++) run_single(vecs[i]);

        // All four at once from a fresh pointer: served 0,1,2,3.
        pulse_reset();
        for (int i = 0; i < 4; i++) set_req(rr[i].id, rr[i].a, rr[i].b);
        for (int j = 0; j < 4; j++) begin
            await_grant(j, g);
            finish_job(g, rr[g].prod, LAT, 1'b0, 0, -1);
        end

        // After serving 1, with 1 and 3 pending, 3 goes first.
        run_single('{1, 32'd6, 32'd7, 64'd42});
        @(negedge clk);
        set_req(1, 32'd6, 32'd7);
        set_req(3, -32'sd2, 32'd3);
        await_grant(3, g);
        finish_job(g, -64'sd6, LAT, 1'b0, 0, -1);
        await_grant(1, g);
        finish_job(g, 64'd42, LAT, 1'b0, 0, -1);

        // Stalled consumer with a competing request; grant right after handshake.
        req_a[2*NB +: NB] = 32'd11;
        req_b[2*NB +: NB] = -32'sd11;
        @(negedge clk);
        set_req(0, 32'd100, 32'd100);
        await_grant(0, g);
        finish_job(g, 64'd10000, LAT, 1'b0, 10, 2);
        chk("grant_after_resp", 64'(req_ready), 64'b0100);
        await_grant(2, g);
        finish_job(g, -64'sd121, LAT, 1'b0, 0, -1);

        // Reset while BUSY abandons the job.
        @(negedge clk);
        set_req(3, 32'd9, 32'd9);
        await_grant(3, g);
        @(negedge clk);
        req_valid[3] = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_mul_start", 64'(mul_start), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        chk("midrst_product", resp_product, 64'd0);
        chk("midrst_resp_id", 64'(resp_id), 64'd0);
        chk("midrst_mul_a", 64'(mul_a), 64'd0);
        chk("midrst_mul_b", 64'(mul_b), 64'd0);
        rst = 1'b0;
        run_single('{1, 32'd1000, -32'sd3, -64'sd3000});

`ifdef BOOTH_SCHED_WDOG_EN
        stall = 1'b1;
        @(negedge clk);
        set_req(2, 32'd5, 32'd5);
        await_grant(2, g);
        finish_job(g, 64'd0, NB/2 + 5, 1'b1, 0, -1);
        stall = 1'b0;
        run_single('{2, 32'd5, 32'd5, 64'd25});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
